// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream register slice: output slot plus skid slot, all outputs registered, latency 1.
// Backpressure: s_tready registered (GREEDY selects accept policy); define AXIS_SKID_FORMAL_EN for protocol properties.
module axis_skid_buf #(
  parameter int GREEDY      = 0,
  parameter int AXIS_DWIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AXIS_DWIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  output logic [AXIS_DWIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready
);

  logic [AXIS_DWIDTH-1:0] skid_dat, skid_dat_nxt, out_dat_nxt;
  logic                   skid_last, skid_last_nxt, skid_vld, skid_vld_nxt;
  logic                   out_last_nxt, out_vld_nxt, rdy_nxt;
  logic                   accept, out_free;

  always_comb begin
    accept        = s_tvalid & s_tready;
    out_free      = ~m_tvalid | m_tready;
    out_dat_nxt   = m_tdata;
    out_last_nxt  = m_tlast;
    out_vld_nxt   = m_tvalid;
    skid_dat_nxt  = skid_dat;
    skid_last_nxt = skid_last;
    skid_vld_nxt  = skid_vld;

    if (out_free) begin
      if (skid_vld) begin
        out_dat_nxt  = skid_dat;
        out_last_nxt = skid_last;
        out_vld_nxt  = 1'b1;
        skid_vld_nxt = accept;
        if (accept) begin
          skid_dat_nxt  = s_tdata;
          skid_last_nxt = s_tlast;
        end
      end else if (accept) begin
        out_dat_nxt  = s_tdata;
        out_last_nxt = s_tlast;
        out_vld_nxt  = 1'b1;
      end else begin
        // Data is left as-is when the slot empties; last must not outlive valid.
        out_vld_nxt  = 1'b0;
        out_last_nxt = 1'b0;
      end
    end else if (accept) begin
      skid_dat_nxt  = s_tdata;
      skid_last_nxt = s_tlast;
      skid_vld_nxt  = 1'b1;
    end

    if (GREEDY != 0) begin
      rdy_nxt = ~(out_vld_nxt & skid_vld_nxt);
    end else begin
      rdy_nxt = s_tready;
      if (accept & ~m_tready) begin
        rdy_nxt = 1'b0;
      end else if (~skid_vld & out_free) begin
        rdy_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_tdata   <= '0;
      m_tlast   <= 1'b0;
      m_tvalid  <= 1'b0;
      skid_dat  <= '0;
      skid_last <= 1'b0;
      skid_vld  <= 1'b0;
      s_tready  <= 1'b0;
    end else begin
      m_tdata   <= out_dat_nxt;
      m_tlast   <= out_last_nxt;
      m_tvalid  <= out_vld_nxt;
      skid_dat  <= skid_dat_nxt;
      skid_last <= skid_last_nxt;
      skid_vld  <= skid_vld_nxt;
      s_tready  <= rdy_nxt;
    end
  end

`ifdef AXIS_SKID_FORMAL_EN
`ifdef AXIS_SKID_FORMAL_STANDALONE
`define AXIS_SKID_UP assume
`else
`define AXIS_SKID_UP assert
`endif

  initial restrict property (!rst);

  // Upstream and downstream-ready obligations: assumed standalone, checked when embedded.
  up_hold: `AXIS_SKID_UP property (@(posedge clk) disable iff (!rst)
    s_tvalid & ~s_tready |=> s_tvalid && $stable(s_tdata) && $stable(s_tlast));
  up_last: `AXIS_SKID_UP property (@(posedge clk) disable iff (!rst) s_tlast |-> s_tvalid);
  dn_rdy:  `AXIS_SKID_UP property (@(posedge clk) disable iff (!rst)
    $fell(m_tready) |-> $past(m_tvalid));

  m_hold: assert property (@(posedge clk) disable iff (!rst)
    m_tvalid & ~m_tready |=> m_tvalid && $stable(m_tdata) && $stable(m_tlast));
  m_last: assert property (@(posedge clk) disable iff (!rst) m_tlast |-> m_tvalid);
  s_fall: assert property (@(posedge clk) disable iff (!rst)
    $fell(s_tready) |-> $past(s_tvalid));

`undef AXIS_SKID_UP
`endif

endmodule

// File: tb/tb_axis_skid_buf.sv
// Bench for axis_skid_buf: one conservative (index 0) and one greedy (index 1) instance
// checked against a queue-based occupancy model plus directed steps.
module tb_axis_skid_buf;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] s_tdata  [2];
  logic         s_tlast  [2];
  logic         s_tvalid [2];
  logic         s_tready [2];
  logic [W-1:0] m_tdata  [2];
  logic         m_tlast  [2];
  logic         m_tvalid [2];
  logic         m_tready [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axis_skid_buf #(.GREEDY(g), .AXIS_DWIDTH(W)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .s_tdata  (s_tdata[g]),
      .s_tlast  (s_tlast[g]),
      .s_tvalid (s_tvalid[g]),
      .s_tready (s_tready[g]),
      .m_tdata  (m_tdata[g]),
      .m_tlast  (m_tlast[g]),
      .m_tvalid (m_tvalid[g]),
      .m_tready (m_tready[g])
    );
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: contents of the buffer as a FIFO of {last,data}, plus expected s_tready.
  logic [W:0]   exp_q [2][$];
  logic         exp_rdy    [2];
  logic         prev_stall [2];
  logic         prev_rdy   [2];
  logic         prev_acc   [2];
  logic [W+1:0] prev_out   [2];
  int           n_out      [2];

  initial begin
    n_out[0] = 0;
    n_out[1] = 0;
  end

  always @(negedge clk) begin
    int   sz, szn;
    logic acc, xfer;
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        exp_q[i].delete();
        exp_rdy[i]    = 1'b0;
        prev_stall[i] = 1'b0;
        prev_rdy[i]   = 1'b0;
        prev_acc[i]   = 1'b0;
      end else begin
        sz = exp_q[i].size();
        chk($sformatf("occ_vld%0d", i), 64'(m_tvalid[i]), 64'(sz != 0));
        if (sz != 0) chk($sformatf("head%0d", i), 64'({m_tlast[i], m_tdata[i]}), 64'(exp_q[i][0]));
        chk($sformatf("last_gate%0d", i), 64'(m_tlast[i] & ~m_tvalid[i]), 64'(0));
        chk($sformatf("rdy%0d", i), 64'(s_tready[i]), 64'(exp_rdy[i]));
        chk($sformatf("fall_after_acc%0d", i), 64'(prev_rdy[i] & ~s_tready[i] & ~prev_acc[i]), 64'(0));
        if (prev_stall[i])
          chk($sformatf("stall_hold%0d", i), 64'({m_tvalid[i], m_tlast[i], m_tdata[i]}), 64'(prev_out[i]));

        acc  = s_tvalid[i] & s_tready[i];
        xfer = m_tvalid[i] & m_tready[i];
        if (xfer && sz != 0) begin
          void'(exp_q[i].pop_front());
          n_out[i]++;
        end
        if (acc) exp_q[i].push_back({s_tlast[i], s_tdata[i]});
        szn = exp_q[i].size();
        if (i == 1) begin
          exp_rdy[i] = (szn != 2);
        end else if (acc && !m_tready[i]) begin
          exp_rdy[i] = 1'b0;
        end else if (sz <= 1 && (sz == 0 || xfer)) begin
          exp_rdy[i] = 1'b1;
        end
        prev_stall[i] = m_tvalid[i] & ~m_tready[i];
        prev_out[i]   = {m_tvalid[i], m_tlast[i], m_tdata[i]};
        prev_rdy[i]   = s_tready[i];
        prev_acc[i]   = acc;
      end
    end
  end

  logic [W-1:0] got [$];
  logic         acc_now [2];
  int           sent    [2];
  int           base    [2];
  logic         acc1;

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_tdata[i]  = '0;
      s_tlast[i]  = 1'b0;
      s_tvalid[i] = 1'b0;
      m_tready[i] = 1'b1;
    end

    // Reset held for 3 clocks.
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("rst_vld%0d", i), 64'(m_tvalid[i]), 64'(0));
        chk($sformatf("rst_dat%0d", i), 64'(m_tdata[i]), 64'(0));
        chk($sformatf("rst_rdy%0d", i), 64'(s_tready[i]), 64'(0));
      end
    end
    rst = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) chk($sformatf("rdy_after_rst%0d", i), 64'(s_tready[i]), 64'(1));

    // Eight-beat packet, no backpressure: one beat per clock, latency 1.
    for (int k = 1; k <= 8; k++) begin
      for (int i = 0; i < 2; i++) begin
        s_tvalid[i] = 1'b1;
        s_tdata[i]  = W'(k);
        s_tlast[i]  = (k == 8);
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("stream_dat%0d", i), 64'({m_tvalid[i], m_tdata[i]}), 64'({1'b1, W'(k)}));
        chk($sformatf("stream_last%0d", i), 64'(m_tlast[i]), 64'(k == 8));
        chk($sformatf("stream_rdy%0d", i), 64'(s_tready[i]), 64'(1));
      end
    end
    for (int i = 0; i < 2; i++) s_tvalid[i] = 1'b0;
    tick();
    tick();

    // Greedy: fills both slots, third beat waits upstream.
    m_tready[1] = 1'b0;
    s_tvalid[1] = 1'b1; s_tdata[1] = 32'hA; s_tlast[1] = 1'b0;
    tick();
    s_tdata[1] = 32'hB;
    tick();
    chk("g1_full_rdy", 64'(s_tready[1]), 64'(0));
    s_tdata[1] = 32'hC;
    tick();
    tick();
    chk("g1_hold_rdy", 64'(s_tready[1]), 64'(0));
    chk("g1_hold_dat", 64'(m_tdata[1]), 64'(32'hA));
    m_tready[1] = 1'b1;
    got.delete();
    for (int c = 0; c < 8; c++) begin
      acc1 = s_tvalid[1] & s_tready[1];
      if (m_tvalid[1]) got.push_back(m_tdata[1]);
      tick();
      if (acc1) s_tvalid[1] = 1'b0;
    end
    chk("g1_cnt", 64'(got.size()), 64'(3));
    chk("g1_seq", {got[0][15:0], got[1][15:0], got[2][15:0]}, 64'h000A_000B_000C);

    // Conservative: ready drops after the first accept with m_tready low.
    chk("g0_rdy_pre", 64'(s_tready[0]), 64'(1));
    m_tready[0] = 1'b0;
    s_tvalid[0] = 1'b1; s_tdata[0] = 32'hA; s_tlast[0] = 1'b0;
    tick();
    chk("g0_rdy_drop", 64'(s_tready[0]), 64'(0));
    s_tdata[0] = 32'hB; s_tlast[0] = 1'b1;
    tick();
    tick();
    chk("g0_hold_rdy", 64'(s_tready[0]), 64'(0));
    chk("g0_hold_dat", 64'({m_tvalid[0], m_tdata[0]}), 64'({1'b1, 32'hA}));
    m_tready[0] = 1'b1;
    got.delete();
    for (int c = 0; c < 8; c++) begin
      acc1 = s_tvalid[0] & s_tready[0];
      if (m_tvalid[0]) got.push_back(m_tdata[0]);
      tick();
      if (acc1) s_tvalid[0] = 1'b0;
    end
    chk("g0_cnt", 64'(got.size()), 64'(2));
    chk("g0_seq", {got[0][31:0], got[1][31:0]}, {32'hA, 32'hB});

    // Random traffic: 1000 beats per instance, checked by the model on every cycle.
    for (int i = 0; i < 2; i++) begin
      sent[i] = 0;
      base[i] = n_out[i];
    end
    for (int c = 0; c < 20000; c++) begin
      if (n_out[0] - base[0] == 1000 && n_out[1] - base[1] == 1000) break;
      for (int i = 0; i < 2; i++) begin
        acc_now[i]  = s_tvalid[i] & s_tready[i];
        m_tready[i] = ($urandom_range(0, 3) != 0);
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        if (acc_now[i] || !s_tvalid[i]) begin
          if (sent[i] < 1000 && $urandom_range(0, 3) != 0) begin
            s_tvalid[i] = 1'b1;
            s_tdata[i]  = W'($urandom);
            s_tlast[i]  = ($urandom_range(0, 7) == 0);
            sent[i]++;
          end else begin
            s_tvalid[i] = 1'b0;
          end
        end
      end
    end
    for (int i = 0; i < 2; i++)
      chk($sformatf("rand_beats%0d", i), 64'(n_out[i] - base[i]), 64'(1000));

    // Reset with beats buffered: outputs clear immediately, old beats never reappear.
    for (int i = 0; i < 2; i++) begin
      m_tready[i] = 1'b0;
      s_tvalid[i] = 1'b1; s_tdata[i] = 32'h55; s_tlast[i] = 1'b0;
    end
    tick();
    for (int i = 0; i < 2; i++) s_tdata[i] = 32'h56;
    tick();
    #1;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("arst_vld%0d", i), 64'(m_tvalid[i]), 64'(0));
      chk($sformatf("arst_dat%0d", i), 64'(m_tdata[i]), 64'(0));
      chk($sformatf("arst_rdy%0d", i), 64'(s_tready[i]), 64'(0));
      s_tvalid[i] = 1'b0;
    end
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) m_tready[i] = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      s_tvalid[i] = 1'b1; s_tdata[i] = 32'h77; s_tlast[i] = 1'b1;
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("post_rst_beat%0d", i), 64'({m_tvalid[i], m_tlast[i], m_tdata[i]}), 64'({2'b11, 32'h77}));
      s_tvalid[i] = 1'b0;
    end
    tick();
    for (int i = 0; i < 2; i++) chk($sformatf("post_rst_empty%0d", i), 64'(m_tvalid[i]), 64'(0));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
